// File: rtl/parity_gen_chk.sv
// Multi-lane parity generator/checker: one output register stage, valid/ready on
// both sides, per-lane parity + mismatch flags, saturating error-beat counter.

module parity_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  par_en,
    input  logic [1:0]            par_typ,
    input  logic                  chk_en,
    input  logic                  rx_par,
    output logic                  par,
    output logic                  err
);
    always_comb begin
        par = 1'b0;
        if (par_en) begin
            case (par_typ)
                2'b00:   par = ^d;
                2'b01:   par = ~^d;
                2'b10:   par = 1'b1;
                default: par = 1'b0;
            endcase
        end
        err = chk_en && par_en && (rx_par != par);
    end
endmodule

module parity_gen_chk #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_LANES     = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_LANES-1:0]            in_rx_par,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            PAR_EN,
    input  logic [1:0]                      PAR_TYP,
    input  logic                            CHK_EN,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]            out_par,
    output logic [NUM_LANES-1:0]            out_err,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ERR_CNT_WIDTH-1:0]        err_cnt,
    input  logic                            cnt_clr
);
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lanes;
    logic [NUM_LANES-1:0]                 par_c;
    logic [NUM_LANES-1:0]                 err_c;
    logic                                 accept;
    logic                                 consume;

    assign lanes    = in_data;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // Mode inputs feed the lanes directly; they only matter on the accepting edge.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        parity_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .d       (lanes[i]),
            .par_en  (PAR_EN),
            .par_typ (PAR_TYP),
            .chk_en  (CHK_EN),
            .rx_par  (in_rx_par[i]),
            .par     (par_c[i]),
            .err     (err_c[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_par   <= '0;
            out_err   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_par   <= par_c;
            out_err   <= err_c;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Counted on the output handshake so a stalled bad beat counts once.
    always_ff @(posedge CLK) begin
        if (RST || cnt_clr)
            err_cnt <= '0;
        else if (consume && (|out_err) && (err_cnt != {ERR_CNT_WIDTH{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_parity_gen_chk.sv
// Directed bench for parity_gen_chk; a 2-bit error counter exposes saturation quickly.

module tb_parity_gen_chk;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_rx_par = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        PAR_EN = 1'b0;
    logic [1:0]  PAR_TYP = 2'b00;
    logic        CHK_EN = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_par;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  err_cnt;
    logic        cnt_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    parity_gen_chk #(.DATA_WIDTH(8), .NUM_LANES(4), .ERR_CNT_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_rx_par(in_rx_par),
        .in_valid(in_valid), .in_ready(in_ready), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .CHK_EN(CHK_EN), .out_data(out_data),
        .out_par(out_par), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] bp [8];
    int          s, r;
    logic        mv, acc;

    initial begin
        // Reset state
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_par", out_par, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cnt", err_cnt, 0);
        RST = 1'b0;
        step();
        chk("rst_ready", in_ready, 1);

        // Generate mode, all parity types back to back
        in_data = 32'h00FF0103; PAR_EN = 1'b1; PAR_TYP = 2'b00;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("even_valid", out_valid, 1);
        chk("even_data", out_data, 32'h00FF0103);
        chk("even_par", out_par, 4'b0010);
        chk("even_err", out_err, 4'b0000);
        PAR_TYP = 2'b01; step();
        chk("odd_par", out_par, 4'b1101);
        PAR_TYP = 2'b10; step();
        chk("mark_par", out_par, 4'b1111);
        PAR_TYP = 2'b11; step();
        chk("space_par", out_par, 4'b0000);
        PAR_EN = 1'b0; PAR_TYP = 2'b01; step();
        chk("dis_par", out_par, 4'b0000);
        in_valid = 1'b0; step();
        chk("drain_valid", out_valid, 0);
        chk("gen_cnt", err_cnt, 0);

        // Check mode with a 5-cycle stall; upstream changes must not leak in
        CHK_EN = 1'b1; PAR_EN = 1'b1; PAR_TYP = 2'b00; in_rx_par = 4'b0011;
        in_data = 32'h00FF0103; in_valid = 1'b1; out_ready = 1'b0;
        step();
        chk("chk_err", out_err, 4'b0001);
        in_data = 32'hDEADBEEF; PAR_TYP = 2'b01; in_rx_par = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 32'h00FF0103);
            chk("stall_par", out_par, 4'b0010);
            chk("stall_err", out_err, 4'b0001);
            chk("stall_cnt", err_cnt, 0);
            chk("stall_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("hs_cnt", err_cnt, 1);
        chk("hs_valid", out_valid, 0);
        chk("stale_err", out_err, 4'b0001);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("clr_cnt", err_cnt, 0);

        // Backpressure stream: out_ready toggles 1,0,1,0...
        CHK_EN = 1'b0; PAR_TYP = 2'b00;
        for (int i = 0; i < 8; i++) bp[i] = {4{8'(i * 37 + 1)}};
        s = 0; r = 0; mv = 1'b0;
        for (int c = 0; c < 40 && r < 8; c++) begin
            out_ready = (c % 2 == 0);
            in_valid  = (s < 8);
            in_data   = bp[(s < 8) ? s : 0];
            #1;
            chk("bp_ready", in_ready, !mv || out_ready);
            if (mv && out_ready) begin
                chk("bp_data", out_data, bp[r]);
                r++;
            end
            acc = in_valid && (!mv || out_ready);
            if (acc) s++;
            mv = acc || (mv && !out_ready);
            step();
            chk("bp_valid", out_valid, mv);
        end
        chk("bp_count", r, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_nodup", out_valid, 0);

        // Full throughput: 8 beats finish in 9 edges
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = bp[7 - i];
            step();
            chk("tp_valid", out_valid, 1);
            chk("tp_data", out_data, bp[7 - i]);
            chk("tp_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("tp_done", out_valid, 0);

        // Saturation of the 2-bit counter, then clear beating an increment
        CHK_EN = 1'b1; PAR_EN = 1'b1; PAR_TYP = 2'b00;
        in_data = 32'h00FF0103; in_rx_par = 4'b0011; in_valid = 1'b1;
        step(); chk("sat0", err_cnt, 0);
        step(); chk("sat1", err_cnt, 1);
        step(); chk("sat2", err_cnt, 2);
        step(); chk("sat3", err_cnt, 3);
        step(); chk("sat4", err_cnt, 3);
        in_valid = 1'b0;
        step(); chk("sat5", err_cnt, 3);
        in_valid = 1'b1; step();
        in_valid = 1'b0; cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("clr_prio", err_cnt, 0);
        chk("clr_valid", out_valid, 0);

        // Reset with a held beat and a nonzero counter
        in_valid = 1'b1; step();
        in_valid = 1'b0; step();
        chk("pre_rst_cnt", err_cnt, 1);
        in_valid = 1'b1; out_ready = 1'b0; step();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        RST = 1'b1; step(); RST = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", err_cnt, 0);
        chk("mid_rst_data", out_data, 0);
        out_ready = 1'b1; step();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_gen_chk.md
Name: parity_gen_chk

Overview:
- Multi-lane, pipelined parity generator/checker for the UART datapath. Successor to the single-byte, edge-triggered parity calculator.
- Computes one parity bit per DATA_WIDTH lane of a NUM_LANES-wide word, in four parity modes plus disable.
- Optionally checks received parity and keeps a saturating error counter.
- Sits between the frame buffer and the TX serializer (generate) or the RX deserializer (check), with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 8, bits per lane
- NUM_LANES, 4, number of independent parity lanes
- ERR_CNT_WIDTH, 8, width of saturating parity-error counter

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- in_data  in  NUM_LANES*DATA_WIDTH  input word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_rx_par  in  NUM_LANES  received parity per lane, used when CHK_EN=1
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- PAR_EN  in  1  parity enable
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- CHK_EN  in  1  1 = check mode, 0 = generate only
- out_data  out  NUM_LANES*DATA_WIDTH  registered copy of in_data
- out_par  out  NUM_LANES  computed parity per lane
- out_err  out  NUM_LANES  per-lane mismatch flag
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- err_cnt  out  ERR_CNT_WIDTH  count of output beats with any out_err bit set
- cnt_clr  in  1  clear err_cnt

Behaviour:
- Reset (RST=1 at a rising edge): out_valid=0, out_data=0, out_par=0, out_err=0, err_cnt=0. in_ready reads 1 from the first cycle after reset. Reset mid-transfer drops the held beat; no partial output is produced.
- Single pipeline register, latency 1. A beat is accepted when in_valid && in_ready at edge N; out_valid=1 from edge N onward until consumed.
- in_ready = !out_valid || out_ready (combinational). Back-to-back accept and consume in the same cycle is allowed, giving full throughput.
- Output hold: while out_valid && !out_ready, all out_* signals stay stable. Upstream in_data changes are ignored.
- Consume with no new accept in the same cycle: out_valid falls to 0. out_data, out_par and out_err keep their stale values.
- Sampling: PAR_EN, PAR_TYP and CHK_EN are sampled only at acceptance and apply to that beat. Changes between beats never affect a beat already held.
- Parity per lane i, with d = lane data:
  - PAR_EN=0: par=0.
  - 00 even: par = ^d.
  - 01 odd: par = ~^d.
  - 10 mark: par=1.
  - 11 space: par=0.
- Error per lane: out_err[i] = CHK_EN && PAR_EN && (in_rx_par[i] != par[i]). Otherwise 0.
- err_cnt:
  - Evaluated at the output handshake (out_valid && out_ready): +1 if |out_err, once per beat regardless of how many lanes failed.
  - Saturates at 2^ERR_CNT_WIDTH-1; no wrap.
  - cnt_clr has priority: on an edge with cnt_clr=1, err_cnt becomes 0 and a concurrent increment is discarded.
  - Counted at handshake, not at accept, so a stalled erroneous beat counts exactly once.
- No FSM beyond the valid bit: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on consume+accept or on stall.
  - FULL→EMPTY on consume with no accept.

Test Plan:
- Reset, then in_data=32'h00_FF_01_03, PAR_EN=1, PAR_TYP=00, out_ready=1 → one cycle later out_valid=1, out_par=4'b0010 (lane1=01 odd count → 1; others even → 0), out_err=0.
- Same data, PAR_TYP=01 → out_par=4'b1101. PAR_TYP=10 → 4'b1111. PAR_TYP=11 → 4'b0000. PAR_EN=0 with any PAR_TYP → 4'b0000.
- Check mode: CHK_EN=1, even, in_data=32'h00_FF_01_03, in_rx_par=4'b0011 → out_err=4'b0001. After the handshake err_cnt=1. Hold out_ready=0 for 5 cycles first → outputs stable and err_cnt stays 0 until the handshake.
- Backpressure and throughput: stream 8 beats with out_ready toggling 1,0,1,0… → every beat emitted once, in order, no loss or duplication. With out_ready=1 continuously, 8 beats complete in 9 cycles.
- Saturation and clear: ERR_CNT_WIDTH=2, send 5 erroneous beats → err_cnt=3. Assert cnt_clr in the same cycle as a 6th erroneous handshake → err_cnt=0.
- Reset mid-operation: assert RST while out_valid=1 and out_ready=0 → next cycle out_valid=0 and err_cnt=0. The held beat never appears.
